// File: rtl/fifo_stream_reader_if.sv
// Handshake bundle between a show-ahead sync FIFO, the stream reader and the
// narrow downstream consumer. The reader is the master of both sides: it pops
// the FIFO and sources the valid/ready stream.
//
// Stream handshake: a beat moves on a rising clock edge where out_valid and
// out_ready are both high. Once out_valid is raised, out_data and out_last
// hold steady until that transfer happens. The one exception is a flush, which
// withdraws the beat. out_valid never waits on out_ready.
// FIFO side: fifo_dequeue_en pops the head word on the same edge. It is only
// raised while fifo_empty is low.
interface fifo_stream_reader_if #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 16
);
    logic                 fifo_empty;
    logic [IN_WIDTH-1:0]  fifo_dequeue_value;
    logic                 fifo_dequeue_en;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_last;

    modport master (
        input  fifo_empty,
        input  fifo_dequeue_value,
        input  out_ready,
        output fifo_dequeue_en,
        output out_valid,
        output out_data,
        output out_last
    );

    modport slave (
        output fifo_empty,
        output fifo_dequeue_value,
        output out_ready,
        input  fifo_dequeue_en,
        input  out_valid,
        input  out_data,
        input  out_last
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a show-ahead sync FIFO and replays each word downstream as RATIO
// narrower beats, least-significant beat first. When the last beat of a word
// is accepted, the next word is popped in the same cycle, so back-to-back
// words stream without a bubble. IN_WIDTH must be a power-of-two multiple of
// OUT_WIDTH.
module fifo_stream_reader #(
    parameter int IN_WIDTH    = 64,
    parameter int OUT_WIDTH   = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_flush_en,
    fifo_stream_reader_if.master   bus,
    output logic                   o_busy,
    output logic [COUNT_WIDTH-1:0] o_words_read,
    output logic                   o_dbg_state
);
    localparam int RATIO  = IN_WIDTH / OUT_WIDTH;
    localparam int BEAT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [BEAT_W-1:0]      r_beat;
    logic [BEAT_W-1:0]      w_next_beat;
    logic [IN_WIDTH-1:0]    r_word;
    logic [COUNT_WIDTH-1:0] r_words_read;
    logic                   w_load;
    logic                   w_transfer;
    logic [OUT_WIDTH-1:0]   w_data;
    logic [OUT_WIDTH-1:0]   w_beats [RATIO];

    // Slice the held word into its beats; beat 0 is the least-significant slice.
    for (genvar g = 0; g < RATIO; g++) begin : g_split
        assign w_beats[g] = r_word[g*OUT_WIDTH +: OUT_WIDTH];
    end

    if (RATIO == 1) begin : g_single
        assign w_data = w_beats[0];
    end else begin : g_multi
        assign w_data = w_beats[r_beat];
    end

    assign w_transfer = (r_state == ST_HOLD) && bus.out_ready;

    // Next-state and pop decision. A flush beats both transfer and load.
    // A load always restarts at beat 0 in HOLD.
    always_comb begin
        w_next_state = r_state;
        w_next_beat  = r_beat;
        w_load       = 1'b0;
        if (i_flush_en) begin
            w_next_state = ST_EMPTY;
            w_next_beat  = '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (!bus.fifo_empty) begin
                        w_load = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (w_transfer) begin
                        if (r_beat != LAST_BEAT) begin
                            w_next_beat = r_beat + 1'b1;
                        end else if (!bus.fifo_empty) begin
                            w_load = 1'b1;
                        end else begin
                            w_next_state = ST_EMPTY;
                        end
                    end
                end
                default: w_next_state = ST_EMPTY;
            endcase
        end
        // While reset is held nothing may be popped, even with the FIFO
        // non-empty; the EMPTY-state load path would otherwise fire.
        if (!i_rst_n) begin
            w_load = 1'b0;
        end
        if (w_load) begin
            w_next_state = ST_HOLD;
            w_next_beat  = '0;
        end
    end

    // State, beat index, held word and pop counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_EMPTY;
            r_beat       <= '0;
            r_word       <= '0;
            r_words_read <= '0;
        end else begin
            r_state <= w_next_state;
            r_beat  <= w_next_beat;
            if (w_load) begin
                r_word       <= bus.fifo_dequeue_value;
                r_words_read <= r_words_read + 1'b1;
            end
        end
    end

    assign bus.fifo_dequeue_en = w_load;
    assign bus.out_valid       = (r_state == ST_HOLD);
    assign bus.out_data        = w_data;
    assign bus.out_last        = (r_state == ST_HOLD) && (r_beat == LAST_BEAT);
    assign o_busy              = (r_state == ST_HOLD);
    assign o_words_read        = r_words_read;
    assign o_dbg_state         = r_state;

`ifndef SYNTHESIS
    a_no_pop_when_empty: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(bus.fifo_dequeue_en && bus.fifo_empty));

    a_data_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (bus.out_valid && !bus.out_ready && !i_flush_en) |=> $stable(bus.out_data));
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_stream_reader_if #(.IN_WIDTH(64), .OUT_WIDTH(16)) bus_a ();
  fifo_stream_reader_if #(.IN_WIDTH(64), .OUT_WIDTH(64)) bus_b ();

  logic        flush_a, flush_b, busy_a, busy_b, st_a, st_b;
  logic [15:0] wr_a;
  logic [2:0]  wr_b;

  fifo_stream_reader #(.IN_WIDTH(64), .OUT_WIDTH(16), .COUNT_WIDTH(16)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush_en(flush_a), .bus(bus_a),
    .o_busy(busy_a), .o_words_read(wr_a), .o_dbg_state(st_a)
  );

  fifo_stream_reader #(.IN_WIDTH(64), .OUT_WIDTH(64), .COUNT_WIDTH(3)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush_en(flush_b), .bus(bus_b),
    .o_busy(busy_b), .o_words_read(wr_b), .o_dbg_state(st_b)
  );

  // FIFO models and scoreboards ({last, data} per beat)
  logic [63:0] fifo_a[$];
  logic [63:0] fifo_b[$];
  logic [16:0] exp_q[$];
  logic [64:0] exp_b_q[$];

  int checks = 0;
  int errors = 0;
  int deq_a = 0, deq_b = 0, vcyc_a = 0;
  logic        s_valid_a, s_deq_a, s_valid_b;
  logic [15:0] s_data_a;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifos();
    bus_a.fifo_empty = (fifo_a.size() == 0);
    bus_a.fifo_dequeue_value = '0;
    if (fifo_a.size() != 0) bus_a.fifo_dequeue_value = fifo_a[0];
    bus_b.fifo_empty = (fifo_b.size() == 0);
    bus_b.fifo_dequeue_value = '0;
    if (fifo_b.size() != 0) bus_b.fifo_dequeue_value = fifo_b[0];
  endtask

  task automatic push_a(input logic [63:0] w);
    fifo_a.push_back(w);
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), w[i*16 +: 16]});
    drive_fifos();
  endtask

  task automatic push_b(input logic [63:0] w);
    fifo_b.push_back(w);
    exp_b_q.push_back({1'b1, w});
    drive_fifos();
  endtask

  // Remove the remaining beats of the word currently held by DUT A.
  task automatic drop_word_a();
    logic [16:0] t;
    while (exp_q.size() != 0) begin
      t = exp_q.pop_front();
      if (t[16]) break;
    end
  endtask

  // One clock: sample at negedge, then update the FIFO models just after posedge.
  task automatic step();
    logic da, db;
    @(negedge clk);
    s_valid_a = bus_a.out_valid;
    s_data_a  = bus_a.out_data;
    s_deq_a   = bus_a.fifo_dequeue_en;
    s_valid_b = bus_b.out_valid;
    da = bus_a.fifo_dequeue_en;
    db = bus_b.fifo_dequeue_en;
    if (da) begin
      deq_a++;
      check("a_pop_while_empty", bus_a.fifo_empty, 1'b0);
    end
    if (db) begin
      deq_b++;
      check("b_pop_while_empty", bus_b.fifo_empty, 1'b0);
    end
    if (bus_a.out_valid) begin
      vcyc_a++;
      if (exp_q.size() == 0) check("a_unexpected_beat", bus_a.out_valid, 1'b0);
      else begin
        check("a_beat", {bus_a.out_last, bus_a.out_data}, exp_q[0]);
        if (flush_a) drop_word_a();
        else if (bus_a.out_ready) void'(exp_q.pop_front());
      end
    end
    if (bus_b.out_valid) begin
      if (exp_b_q.size() == 0) check("b_unexpected_beat", bus_b.out_valid, 1'b0);
      else begin
        check("b_beat", {bus_b.out_last, bus_b.out_data}, exp_b_q[0]);
        if (bus_b.out_ready && !flush_b) void'(exp_b_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
    if (da && fifo_a.size() != 0) void'(fifo_a.pop_front());
    if (db && fifo_b.size() != 0) void'(fifo_b.pop_front());
    drive_fifos();
  endtask

  task automatic drain_a(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    flush_a = 1'b0;
    flush_b = 1'b0;
    bus_a.out_ready = 1'b1;
    bus_b.out_ready = 1'b1;
    drive_fifos();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_a", bus_a.out_valid, 1'b0);
    check("rst_last_a", bus_a.out_last, 1'b0);
    check("rst_busy_a", busy_a, 1'b0);
    check("rst_deq_a", bus_a.fifo_dequeue_en, 1'b0);
    check("rst_words_a", wr_a, 16'd0);
    check("rst_state_a", st_a, 1'b0);
    check("rst_valid_b", bus_b.out_valid, 1'b0);
    check("rst_words_b", wr_b, 3'd0);
    rst_neg: rst_n = 1'b1;
    step();

    // Single word: one pop, four beats, last on the top beat
    deq_a = 0;
    push_a(64'h4444_3333_2222_1111);
    step();
    check("t1_load_valid", s_valid_a, 1'b0);
    check("t1_load_deq", s_deq_a, 1'b1);
    vcyc_a = 0;
    repeat (4) step();
    check("t1_valid_cycles", vcyc_a, 4);
    check("t1_drained", exp_q.size(), 0);
    check("t1_words", wr_a, 16'd1);
    step();
    check("t1_idle_valid", s_valid_a, 1'b0);
    check("t1_deq_count", deq_a, 1);

    // Two words back to back: no bubble, second pop on the 4th beat
    deq_a = 0;
    push_a(64'hDDDD_CCCC_BBBB_AAAA);
    push_a(64'h8888_7777_6666_5555);
    step();
    vcyc_a = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 3) check("t2_deq_on_last_beat", s_deq_a, 1'b1);
    end
    check("t2_valid_cycles", vcyc_a, 8);
    check("t2_deq_count", deq_a, 2);
    check("t2_words", wr_a, 16'd3);
    step();
    check("t2_idle_valid", s_valid_a, 1'b0);

    // Backpressure on beat 1
    deq_a = 0;
    push_a(64'h4444_3333_2222_1111);
    step();
    step();
    bus_a.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_bp_valid", s_valid_a, 1'b1);
      check("t3_bp_data", s_data_a, 16'h2222);
      check("t3_bp_deq", s_deq_a, 1'b0);
    end
    bus_a.out_ready = 1'b1;
    drain_a("t3_drained");
    check("t3_deq_count", deq_a, 1);
    check("t3_words", wr_a, 16'd4);
    step();

    // Flush while beat 2 is shown with out_ready high
    push_a(64'hAAAA_BBBB_CCCC_DDDD);
    repeat (3) step();
    flush_a = 1'b1;
    step();
    check("t4_flush_beat", s_data_a, 16'hBBBB);
    check("t4_flush_deq", s_deq_a, 1'b0);
    flush_a = 1'b0;
    step();
    check("t4_after_valid", s_valid_a, 1'b0);
    check("t4_after_busy", busy_a, 1'b0);
    check("t4_words", wr_a, 16'd5);
    push_a(64'h1234_5678_9ABC_DEF0);
    step();
    step();
    check("t4_restart_beat0", s_data_a, 16'hDEF0);
    drain_a("t4_drained");
    step();

    // Reset mid-word with the FIFO still holding a word
    push_a(64'h0F0F_1E1E_2D2D_3C3C);
    push_a(64'h9999_AAAA_BBBB_CCCC);
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", bus_a.out_valid, 1'b0);
    check("t5_rst_busy", busy_a, 1'b0);
    check("t5_rst_last", bus_a.out_last, 1'b0);
    check("t5_rst_words", wr_a, 16'd0);
    check("t5_rst_deq", bus_a.fifo_dequeue_en, 1'b0);
    drop_word_a();
    deq_a = 0;
    repeat (2) step();
    check("t5_no_pop_in_reset", deq_a, 0);
    rst_n = 1'b1;
    step();
    check("t5_load_valid", s_valid_a, 1'b0);
    check("t5_load_deq", s_deq_a, 1'b1);
    step();
    check("t5_first_beat", s_data_a, 16'hCCCC);
    drain_a("t5_drained");
    check("t5_words", wr_a, 16'd1);

    // RATIO=1 build: random words, toggling ready, 3-bit counter wraps
    deq_b = 0;
    for (int i = 0; i < 5; i++) push_b({$urandom, $urandom});
    for (int i = 0; i < 60 && exp_b_q.size() != 0; i++) begin
      bus_b.out_ready = (i % 2 == 0);
      step();
    end
    bus_b.out_ready = 1'b1;
    check("t6_drained", exp_b_q.size(), 0);
    repeat (3) step();
    check("t6_idle_valid", s_valid_b, 1'b0);
    check("t6_deq_count", deq_b, 5);
    check("t6_words", wr_b, 3'd5);
    for (int i = 0; i < 4; i++) push_b({$urandom, $urandom});
    for (int i = 0; i < 60 && exp_b_q.size() != 0; i++) begin
      bus_b.out_ready = ($urandom_range(0, 1) == 1);
      step();
    end
    bus_b.out_ready = 1'b1;
    check("t6_drained2", exp_b_q.size(), 0);
    repeat (2) step();
    check("t6_words_wrap", wr_b, 3'd1);
    check("t6_deq_count2", deq_b, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
